// File: rtl/main_mem_responder_if.sv
// Cache-to-memory request/ack bundle.
// master: cache controller (rd/wr req, addr, wdata); slave: memory responder (rdata, ack, busy, err).
interface main_mem_responder_if #(
  parameter int ADDR_W = 8,
  parameter int LINE_W = 128
);
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              Main_mem_ack;
  logic              mem_busy;
  logic              protocol_err;

  modport master (
    output mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
    input  mem_rdata, Main_mem_ack, mem_busy, protocol_err
  );

  modport slave (
    input  mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
    output mem_rdata, Main_mem_ack, mem_busy, protocol_err
  );
endinterface

// File: rtl/main_mem_responder.sv
// Line-wide backing store answering level-held rd/wr requests with a one-cycle ack after fixed latency.
// Ports: clk, rst (sync, active-low), bus (slave modport); MEM_STATS_EN adds rd_count/wr_count.
module main_mem_responder #(
  parameter int ADDR_W = 8,
  parameter int LINE_W = 128,
  parameter int RD_LAT = 4,
  parameter int WR_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  main_mem_responder_if.slave  bus
`ifdef MEM_STATS_EN
  ,
  output logic [31:0]          rd_count,
  output logic [31:0]          wr_count
`endif
);

  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] rdata_q;
  logic              ack_q;
  logic              busy_q;
  logic              perr_q;
  logic              wr_done;

  logic [LINE_W-1:0] mem [2**ADDR_W];

  assign bus.mem_rdata    = rdata_q;
  assign bus.Main_mem_ack = ack_q;
  assign bus.mem_busy     = busy_q;
  assign bus.protocol_err = perr_q;

  // Write commits on the ack edge only; an abort or reset blocks it.
  assign wr_done = (state == WRITE) && bus.mem_wr_en && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst && wr_done) begin
      mem[addr_q] <= wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      perr_q  <= 1'b0;
`ifdef MEM_STATS_EN
      rd_count <= '0;
      wr_count <= '0;
`endif
    end else begin
      ack_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.mem_wr_en) begin
            state   <= WRITE;
            addr_q  <= bus.mem_addr;
            wdata_q <= bus.mem_wdata;
            cnt     <= CNT_W'(WR_LAT - 1);
            busy_q  <= 1'b1;
            // Simultaneous rd+wr: write wins, flag it.
            if (bus.mem_rd_en) perr_q <= 1'b1;
          end else if (bus.mem_rd_en) begin
            state  <= READ;
            addr_q <= bus.mem_addr;
            cnt    <= CNT_W'(RD_LAT - 1);
            busy_q <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        READ: begin
          if (!bus.mem_rd_en) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            perr_q <= 1'b1;
          end else if (cnt == '0) begin
            // busy stays high through the ack cycle.
            state   <= IDLE;
            ack_q   <= 1'b1;
            rdata_q <= mem[addr_q];
`ifdef MEM_STATS_EN
            rd_count <= rd_count + 32'd1;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WRITE: begin
          if (!bus.mem_wr_en) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            perr_q <= 1'b1;
          end else if (cnt == '0) begin
            state <= IDLE;
            ack_q <= 1'b1;
`ifdef MEM_STATS_EN
            wr_count <= wr_count + 32'd1;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_main_mem_responder.sv
// Scoreboard bench for main_mem_responder.
// Drives on negedge, samples on negedge; read data expectations are queued at request time.
module tb_main_mem_responder;

  localparam int ADDR_W = 8;
  localparam int LINE_W = 128;
  localparam int RD_LAT = 4;
  localparam int WR_LAT = 2;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [LINE_W-1:0] model [2**ADDR_W];
  logic [LINE_W-1:0] exp_q [$];
  logic [LINE_W-1:0] last_rd;

  main_mem_responder_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

`ifdef MEM_STATS_EN
  logic [31:0] rd_count;
  logic [31:0] wr_count;
`endif

  main_mem_responder #(
    .ADDR_W(ADDR_W),
    .LINE_W(LINE_W),
    .RD_LAT(RD_LAT),
    .WR_LAT(WR_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef MEM_STATS_EN
    ,
    .rd_count(rd_count),
    .wr_count(wr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.mem_rd_en = 1'b0;
    bus.mem_wr_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    last_rd = '0;
  endtask

  // Returns in the ack cycle (at its negedge) with the request still driven.
  task automatic xact(input bit wr, input bit rd,
                      input logic [ADDR_W-1:0] a,
                      input logic [LINE_W-1:0] d);
    int n;
    logic [LINE_W-1:0] e;
    if (!wr) exp_q.push_back(model[a]);
    bus.mem_wr_en = wr;
    bus.mem_rd_en = rd;
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) check("busy_after_accept", 128'(bus.mem_busy), 128'd1);
    end while (!bus.Main_mem_ack && n < 20);
    if (wr) begin
      check("wr_latency", 128'(n), 128'(WR_LAT + 1));
      model[a] = d;
    end else begin
      check("rd_latency", 128'(n), 128'(RD_LAT + 1));
      e = exp_q.pop_front();
      check("rdata", bus.mem_rdata, e);
      last_rd = e;
    end
  endtask

  task automatic idle();
    bus.mem_rd_en = 1'b0;
    bus.mem_wr_en = 1'b0;
    @(negedge clk);
    check("ack_one_wide", 128'(bus.Main_mem_ack), 128'd0);
  endtask

  task automatic abort(input bit wr, input logic [ADDR_W-1:0] a,
                       input logic [LINE_W-1:0] d);
    int acks;
    bus.mem_wr_en = wr;
    bus.mem_rd_en = !wr;
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    @(negedge clk);
    bus.mem_wr_en = 1'b0;
    bus.mem_rd_en = 1'b0;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.Main_mem_ack) acks++;
    end
    check("abort_no_ack", 128'(acks), 128'd0);
    check("abort_rdata", bus.mem_rdata, last_rd);
    check("abort_perr", 128'(bus.protocol_err), 128'd1);
    check("abort_idle", 128'(bus.mem_busy), 128'd0);
  endtask

  initial begin
    logic [LINE_W-1:0] rnd [6];
    int acks;
    checks = 0;
    errors = 0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    for (int i = 0; i < 2**ADDR_W; i++) model[i] = '0;

    do_reset();
    check("rst_ack", 128'(bus.Main_mem_ack), 128'd0);
    check("rst_rdata", bus.mem_rdata, 128'd0);
    check("rst_busy", 128'(bus.mem_busy), 128'd0);
    check("rst_perr", 128'(bus.protocol_err), 128'd0);

    xact(1, 0, 8'h50, '0);
    idle();

    xact(1, 0, 8'h10, {16{8'hA5}});
    idle();
    xact(0, 1, 8'h10, '0);
    idle();

    // write then switch to read in the ack cycle
    xact(1, 0, 8'h20, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    xact(0, 1, 8'h20, '0);
    idle();
    check("perr_clean", 128'(bus.protocol_err), 128'd0);

    // both requests: write wins
    xact(1, 1, 8'h30, 128'd1);
    check("perr_both", 128'(bus.protocol_err), 128'd1);
    idle();
    xact(0, 1, 8'h30, '0);
    idle();
    check("perr_sticky", 128'(bus.protocol_err), 128'd1);

    // aborted write must leave the array untouched
    abort(1, 8'h10, {16{8'h5A}});
    xact(0, 1, 8'h10, '0);
    idle();

    do_reset();
    check("perr_cleared", 128'(bus.protocol_err), 128'd0);
    xact(0, 1, 8'h10, '0);
    idle();
    abort(0, 8'h40, '0);

    for (int i = 0; i < 6; i++) begin
      rnd[i] = {$urandom, $urandom, $urandom, $urandom};
      xact(1, 0, 8'(8'h60 + i), rnd[i]);
      idle();
    end
    for (int i = 5; i >= 0; i--) begin
      xact(0, 1, 8'(8'h60 + i), '0);
      idle();
    end

    // reset in the middle of a write to 0x50
    bus.mem_wr_en = 1'b1;
    bus.mem_rd_en = 1'b0;
    bus.mem_addr  = 8'h50;
    bus.mem_wdata = '1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ack", 128'(bus.Main_mem_ack), 128'd0);
    check("midrst_rdata", bus.mem_rdata, 128'd0);
    check("midrst_busy", 128'(bus.mem_busy), 128'd0);
    check("midrst_perr", 128'(bus.protocol_err), 128'd0);
    bus.mem_wr_en = 1'b0;
    rst = 1'b1;
    last_rd = '0;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.Main_mem_ack) acks++;
    end
    check("midrst_no_ack", 128'(acks), 128'd0);
    xact(0, 1, 8'h50, '0);
    idle();

`ifdef MEM_STATS_EN
    do_reset();
    check("stat_rd_rst", 128'(rd_count), 128'd0);
    check("stat_wr_rst", 128'(wr_count), 128'd0);
    for (int i = 0; i < 3; i++) begin
      xact(0, 1, 8'h10, '0);
      idle();
    end
    for (int i = 0; i < 2; i++) begin
      xact(1, 0, 8'h70, 128'(i + 7));
      idle();
    end
    abort(0, 8'h10, '0);
    check("stat_rd", 128'(rd_count), 128'd3);
    check("stat_wr", 128'(wr_count), 128'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
